// File: rtl/rtmc_step_seq.sv
// rtl/rtmc_step_seq.sv - step-move command sequencer with host/sequencer register-bus arbiter
module rtmc_step_seq #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int CMD_DEPTH = 4,
  parameter int DLY_W     = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_steps,
  input  logic [DLY_W-1:0]  cmd_delay,
  input  logic [4:0]        cmd_size,
  input  logic [3:0]        cmd_last,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  steps_left,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdat,
  input  logic              h_wr,
  input  logic              h_rd,
  output logic [DATA_W-1:0] h_rdat,
  output logic              h_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdat,
  output logic              m_wr,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_rdat,
  input  logic              m_ack
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int ENT_W = CNT_W + DLY_W + 9;
  localparam logic [PTR_W:0]    PTR_ONE   = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [DLY_W-1:0]  DLY_ONE   = 1;
  localparam logic [ADDR_W-1:0] STEP_ADDR = ADDR_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_SEQ} own_t;

  state_t state, state_n;
  own_t   owner, eff_own;

  logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] head_steps;
  logic [DLY_W-1:0] head_delay;
  logic [4:0]       head_size;
  logic [3:0]       head_last;

  logic [CNT_W-1:0]  steps_left_q;
  logic [DLY_W-1:0]  dly_q, cnt_q;
  logic [4:0]        size_q;
  logic [3:0]        last_q;
  logic              abort_pend;
  logic              last_host;
  logic [DATA_W-1:0] h_rdat_q;
  logic [DATA_W-1:0] step_word;
  logic              host_req, seq_req, seq_gnt, seq_ack;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready  = !full && !abort;
  assign push       = cmd_valid && cmd_ready;
  // A pop can only happen in LOAD, which is entered only with the FIFO non-empty.
  assign pop        = (state == S_LOAD) && !abort;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_steps = head[ENT_W-1 -: CNT_W];
  assign head_delay = head[9 +: DLY_W];
  assign head_size  = head[8:4];
  assign head_last  = head[3:0];

  assign host_req   = h_wr || h_rd;
  assign seq_req    = (state == S_STEP);
  assign seq_gnt    = (eff_own == OWN_SEQ);
  assign seq_ack    = seq_gnt && m_ack;

  assign busy       = !empty || (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign steps_left = steps_left_q;

  // Command storage; entries are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_steps, cmd_delay, cmd_size, cmd_last};
  end

  // FIFO pointers; abort flushes everything queued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Sequencer next state; an abort during a granted write waits for its ack.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (!empty && !abort) state_n = S_LOAD;
      S_LOAD: begin
        if (abort)                    state_n = S_IDLE;
        else if (head_steps == '0)    state_n = S_DONE;
        else                          state_n = S_STEP;
      end
      S_STEP: begin
        if (seq_ack) begin
          if (abort || abort_pend)         state_n = S_IDLE;
          else if (steps_left_q == CNT_ONE) state_n = S_DONE;
          else                             state_n = S_WAIT;
        end else if (abort && !seq_gnt) begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (abort)             state_n = S_IDLE;
        else if (cnt_q == '0)  state_n = S_STEP;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Step counter, inter-step delay counter and latched command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_left_q <= '0;
      dly_q        <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      last_q       <= '0;
      abort_pend   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: abort_pend <= 1'b0;
        S_LOAD: begin
          if (abort) begin
            steps_left_q <= '0;
          end else begin
            steps_left_q <= head_steps;
            dly_q        <= head_delay;
            size_q       <= head_size;
            last_q       <= head_last;
          end
        end
        S_STEP: begin
          if (seq_ack) begin
            steps_left_q <= (abort || abort_pend) ? '0 : steps_left_q - CNT_ONE;
            cnt_q        <= dly_q;
          end else if (abort) begin
            if (seq_gnt) abort_pend   <= 1'b1;
            else         steps_left_q <= '0;
          end
        end
        S_WAIT: begin
          if (abort)              steps_left_q <= '0;
          else if (cnt_q != '0)   cnt_q <= cnt_q - DLY_ONE;
        end
        default: ;
      endcase
    end
  end

  // STEP_CTRL write word: bit14 set, table limit in [8:5], signed step size in [4:0].
  always_comb begin
    step_word      = '0;
    step_word[14]  = 1'b1;
    step_word[8:5] = last_q;
    step_word[4:0] = size_q;
  end

  // Effective bus owner: the registered owner keeps the bus while it requests,
  // otherwise a fresh grant is made this cycle so a new request is not delayed.
  always_comb begin
    eff_own = OWN_NONE;
    if (owner == OWN_HOST && host_req)     eff_own = OWN_HOST;
    else if (owner == OWN_SEQ && seq_req)  eff_own = OWN_SEQ;
    else if (host_req && seq_req)          eff_own = last_host ? OWN_SEQ : OWN_HOST;
    else if (host_req)                     eff_own = OWN_HOST;
    else if (seq_req)                      eff_own = OWN_SEQ;
  end

  // Owner register, last-served flag and held host read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      last_host <= 1'b0;
      h_rdat_q  <= '0;
    end else begin
      owner <= eff_own;
      if (eff_own == OWN_HOST) last_host <= 1'b1;
      else if (eff_own == OWN_SEQ) last_host <= 1'b0;
      if (eff_own == OWN_HOST && m_ack) h_rdat_q <= m_rdat;
    end
  end

  // Downstream bus mux and host response path.
  always_comb begin
    m_addr = '0;
    m_wdat = '0;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    h_ack  = 1'b0;
    h_rdat = h_rdat_q;
    case (eff_own)
      OWN_HOST: begin
        m_addr = h_addr;
        m_wdat = h_wdat;
        m_wr   = h_wr;
        m_rd   = h_rd;
        h_ack  = m_ack;
        h_rdat = m_rdat;
      end
      OWN_SEQ: begin
        m_addr = STEP_ADDR;
        m_wdat = step_word;
        m_wr   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rtmc_step_seq.sv
// tb/tb_rtmc_step_seq.sv - self-checking bench for rtmc_step_seq
module tb_rtmc_step_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic [31:0] cmd_delay = '0;
  logic [4:0]  cmd_size = '0;
  logic [3:0]  cmd_last = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [15:0] steps_left;
  logic [7:0]  h_addr = '0;
  logic [15:0] h_wdat = '0;
  logic        h_wr = 1'b0, h_rd = 1'b0;
  logic [15:0] h_rdat;
  logic        h_ack;
  logic [7:0]  m_addr;
  logic [15:0] m_wdat;
  logic        m_wr, m_rd;
  logic [15:0] m_rdat;
  logic        m_ack;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] exp_wdat[$];
  int exp_done = 0;
  int ack_q[$];
  int done_q[$];
  int m_req_cycles = 0;

  rtmc_step_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .cmd_delay(cmd_delay), .cmd_size(cmd_size), .cmd_last(cmd_last),
    .abort(abort), .busy(busy), .done(done), .steps_left(steps_left),
    .h_addr(h_addr), .h_wdat(h_wdat), .h_wr(h_wr), .h_rd(h_rd),
    .h_rdat(h_rdat), .h_ack(h_ack),
    .m_addr(m_addr), .m_wdat(m_wdat), .m_wr(m_wr), .m_rd(m_rd),
    .m_rdat(m_rdat), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream target: ack toggles every cycle a request is held; addr 0 is the ID register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ack <= 1'b0;
    else        m_ack <= (m_wr || m_rd) ? !m_ack : 1'b0;
  end
  assign m_rdat = (m_addr == 8'd0) ? 16'h0142 : {8'h00, m_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [3:0] last, input logic [4:0] size);
    return 16'h4000 + 16'(last) * 16'd32 + 16'(size);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: each completed downstream write must be the next expected step word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_ack && m_wr) begin
        chk("seq_write_addr", 32'(m_addr), 32'd2);
        chk("seq_write_expected", 32'(exp_wdat.size() != 0), 32'd1);
        if (exp_wdat.size() != 0) chk("seq_write_data", 32'(m_wdat), 32'(exp_wdat.pop_front()));
        ack_q.push_back(cyc);
      end
      if (m_ack && m_rd) chk("host_ack_on_read", 32'(h_ack), 32'd1);
      if (done) begin
        chk("done_expected", 32'(exp_done > 0), 32'd1);
        if (exp_done > 0) exp_done--;
        chk("steps_left_at_done", 32'(steps_left), 32'd0);
        done_q.push_back(cyc);
      end
      if (h_ack) chk("host_rdat", 32'(h_rdat), 32'((h_addr == 8'd0) ? 16'h0142 : {8'h00, h_addr}));
      if (m_wr || m_rd) m_req_cycles++;
    end
  end

  task automatic push(input int steps, input int dly, input logic [4:0] size,
                      input logic [3:0] last, output int pcyc);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_steps = 16'(steps);
    cmd_delay = 32'(dly);
    cmd_size  = size;
    cmd_last  = last;
    while (!cmd_ready && t < 100) begin
      tick(1);
      t++;
    end
    chk("push_ready", 32'(cmd_ready), 32'd1);
    pcyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < steps; i++) exp_wdat.push_back(model_word(last, size));
    exp_done++;
  endtask

  task automatic wait_quiet(input int limit);
    int t = 0;
    while ((busy || exp_wdat.size() != 0) && t < limit) begin
      tick(1);
      t++;
    end
    tick(2);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_writes_left", 32'(exp_wdat.size()), 32'd0);
    chk("drain_done_left", 32'(exp_done), 32'd0);
  endtask

  task automatic wait_seq_ack(output int t_ack);
    int n = 0;
    tick(1);
    while (!(m_wr && m_ack) && n < 200) begin
      tick(1);
      n++;
    end
    chk("seq_ack_seen", 32'(m_wr && m_ack), 32'd1);
    t_ack = cyc;
  endtask

  task automatic host_read(input logic [7:0] addr, input bit tie, input logic want_wr,
                           input logic want_rd, output logic [15:0] data);
    int t = 0;
    h_addr = addr;
    h_rd   = 1'b1;
    #1;
    if (tie) begin
      chk("tie_m_wr", 32'(m_wr), 32'(want_wr));
      chk("tie_m_rd", 32'(m_rd), 32'(want_rd));
    end
    @(posedge clk);
    #1;
    while (!h_ack && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("host_ack_seen", 32'(h_ack), 32'd1);
    data = h_rdat;
    @(posedge clk);
    #1;
    h_rd = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_steps_left"}, 32'(steps_left), 32'd0);
    chk({tag, "_m_wr"}, 32'(m_wr), 32'd0);
    chk({tag, "_m_rd"}, 32'(m_rd), 32'd0);
    chk({tag, "_h_ack"}, 32'(h_ack), 32'd0);
    chk({tag, "_h_rdat"}, 32'(h_rdat), 32'd0);
    chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_m_wdat"}, 32'(m_wdat), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, p0, p4, t, t2, t3, c, r0, nd;
    logic [15:0] d;

    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Single command: steps=3 delay=4 size=+1 last=7.
    ack_q.delete();
    done_q.delete();
    push(3, 4, 5'd1, 4'd7, p);
    tick(1);
    chk("single_no_wr_at_p2", 32'(m_wr), 32'd0);
    tick(1);
    chk("single_wr_at_p3", 32'(m_wr), 32'd1);
    chk("single_addr", 32'(m_addr), 32'd2);
    chk("single_wdat", 32'(m_wdat), 32'h40E1);
    chk("single_steps_left_3", 32'(steps_left), 32'd3);
    tick(2);
    chk("single_steps_left_2", 32'(steps_left), 32'd2);
    wait_quiet(200);
    chk("single_ack_count", 32'(ack_q.size()), 32'd3);
    if (ack_q.size() == 3) begin
      chk("single_ack0", 32'(ack_q[0]), 32'(p + 4));
      chk("single_ack1", 32'(ack_q[1]), 32'(p + 11));
      chk("single_ack2", 32'(ack_q[2]), 32'(p + 18));
    end
    chk("single_done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1) chk("single_done_cycle", 32'(done_q[0]), 32'(p + 19));

    // Negative step size, zero delay.
    ack_q.delete();
    push(2, 0, 5'b11110, 4'd15, p);
    tick(2);
    chk("neg_wdat", 32'(m_wdat), 32'h41FE);
    wait_quiet(100);
    chk("neg_ack_count", 32'(ack_q.size()), 32'd2);
    if (ack_q.size() == 2) begin
      chk("neg_ack0", 32'(ack_q[0]), 32'(p + 4));
      chk("neg_ack_spacing", 32'(ack_q[1] - ack_q[0]), 32'd3);
    end

    // Zero steps: done only, never a bus request.
    r0 = m_req_cycles;
    push(0, 5, 5'd1, 4'd1, p);
    tick(2);
    chk("zero_done_at_p3", 32'(done), 32'd1);
    tick(1);
    chk("zero_done_one_cycle", 32'(done), 32'd0);
    wait_quiet(50);
    chk("zero_no_requests", 32'(m_req_cycles), 32'(r0));

    // Host reads during a move, including arbitration ties in both directions.
    push(6, 6, 5'd1, 4'd3, p);
    wait_seq_ack(t);
    tick(1);
    host_read(8'd0, 1'b0, 1'b0, 1'b0, d);
    chk("host_read_id", 32'(d), 32'h0142);
    tick(5);
    host_read(8'd0, 1'b1, 1'b1, 1'b0, d);
    wait_seq_ack(t2);
    chk("tie_seq_ack_cycle", 32'(t2), 32'(t + 18));
    tick(8);
    host_read(8'd0, 1'b1, 1'b0, 1'b1, d);
    wait_seq_ack(t3);
    chk("tie_host_delays_step", 32'(t3), 32'(t2 + 11));
    wait_quiet(200);

    // FIFO full: five back-to-back pushes.
    done_q.delete();
    push(2, 3, 5'd1, 4'd1, p0);
    push(1, 0, 5'd2, 4'd2, p);
    push(1, 0, 5'd3, 4'd3, p);
    push(2, 1, 5'd4, 4'd4, p);
    push(1, 0, 5'd5, 4'd5, p4);
    chk("full_consecutive_pushes", 32'(p4), 32'(p0 + 4));
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    wait_quiet(500);
    chk("full_done_count", 32'(done_q.size()), 32'd5);

    // Abort in the middle of a long move with more commands queued.
    push(100, 2, 5'd1, 4'd9, p);
    push(3, 0, 5'd1, 4'd10, p);
    push(3, 0, 5'd1, 4'd11, p);
    tick(20);
    c = 0;
    while (!(m_wr && !m_ack) && c < 50) begin
      tick(1);
      c++;
    end
    chk("abort_found_request", 32'(m_wr && !m_ack), 32'd1);
    nd = done_q.size();
    abort = 1'b1;
    exp_wdat.delete();
    exp_wdat.push_back(model_word(4'd9, 5'd1));
    exp_done = 0;
    #1;
    chk("abort_ready_low", 32'(cmd_ready), 32'd0);
    tick(1);
    abort = 1'b0;
    tick(2);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_steps_left", 32'(steps_left), 32'd0);
    chk("abort_no_wr", 32'(m_wr), 32'd0);
    tick(30);
    chk("abort_inflight_completed", 32'(exp_wdat.size()), 32'd0);
    chk("abort_no_done", 32'(done_q.size()), 32'(nd));

    // Asynchronous reset in the middle of WAIT.
    push(5, 10, 5'd1, 4'd2, p);
    wait_seq_ack(t);
    tick(2);
    chk("hold_h_rdat", 32'(h_rdat), 32'h0142);
    chk("wait_busy", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    exp_wdat.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(5);
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
